// File: rtl/line_sequencer.sv
// Program sequencer and Bresenham line rasteriser for the plotter datapath.
// Walks the instruction memory, moving the pen or streaming line pixels out on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | sample instruction memory at pc
// SETUP | compute deltas, steps and initial error
// DRAW  | present pixel, advance on handshake
// NEXT  | advance pc or finish the run
// DONE  | one-cycle done pulse
module line_sequencer #(
   parameter int PROG_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [7:0] pc,
   input  logic [9:0] next_x,
   input  logic [9:0] next_y,
   input  logic [2:0] ch,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic [2:0] pix_color,
   output logic       busy,
   output logic       done
);

   localparam logic [7:0] LAST_PC = 8'(PROG_LEN - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SETUP = 3'd2,
      DRAW  = 3'd3,
      NEXT  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t             r_state;
   logic [7:0]         r_pc;
   logic [9:0]         r_cur_x;
   logic [9:0]         r_cur_y;
   logic [9:0]         r_tx;
   logic [9:0]         r_ty;
   logic [2:0]         r_col;
   logic signed [11:0] r_dx;
   logic signed [11:0] r_dy;
   logic signed [11:0] r_err;
   logic               r_sx;
   logic               r_sy;
   logic [9:0]         r_pix_x;
   logic [9:0]         r_pix_y;
   logic [2:0]         r_pix_color;
   logic               r_pix_valid;
   logic               r_busy;
   logic               r_done;

   logic signed [11:0] w_diff_x;
   logic signed [11:0] w_diff_y;
   logic signed [11:0] w_abs_x;
   logic signed [11:0] w_abs_y;
   logic signed [11:0] w_e2;
   logic               w_step_x;
   logic               w_step_y;
   logic signed [11:0] w_err_next;
   logic [9:0]         w_pix_x_next;
   logic [9:0]         w_pix_y_next;
   logic               w_last_pix;

   // 12-bit signed keeps 2*err in range for full 10-bit spans.
   assign w_diff_x = $signed({2'b00, r_tx}) - $signed({2'b00, r_cur_x});
   assign w_diff_y = $signed({2'b00, r_ty}) - $signed({2'b00, r_cur_y});
   assign w_abs_x  = w_diff_x[11] ? -w_diff_x : w_diff_x;
   assign w_abs_y  = w_diff_y[11] ? -w_diff_y : w_diff_y;

   assign w_e2       = r_err <<< 1;
   assign w_step_x   = (w_e2 >= r_dy);
   assign w_step_y   = (w_e2 <= r_dx);
   assign w_err_next = r_err + (w_step_x ? r_dy : 12'sd0) + (w_step_y ? r_dx : 12'sd0);

   assign w_pix_x_next = !w_step_x ? r_pix_x : (r_sx ? r_pix_x + 10'd1 : r_pix_x - 10'd1);
   assign w_pix_y_next = !w_step_y ? r_pix_y : (r_sy ? r_pix_y + 10'd1 : r_pix_y - 10'd1);
   assign w_last_pix   = (r_pix_x == r_tx) && (r_pix_y == r_ty);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pc        <= 8'd0;
         r_cur_x     <= 10'd0;
         r_cur_y     <= 10'd0;
         r_tx        <= 10'd0;
         r_ty        <= 10'd0;
         r_col       <= 3'd0;
         r_dx        <= 12'sd0;
         r_dy        <= 12'sd0;
         r_err       <= 12'sd0;
         r_sx        <= 1'b0;
         r_sy        <= 1'b0;
         r_pix_x     <= 10'd0;
         r_pix_y     <= 10'd0;
         r_pix_color <= 3'd0;
         r_pix_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_pc    <= 8'd0;
                  r_busy  <= 1'b1;
                  r_state <= FETCH;
               end
            end
            FETCH: begin
               r_tx  <= next_x;
               r_ty  <= next_y;
               r_col <= ch;
               if (ch == 3'd0) begin
                  r_cur_x <= next_x;
                  r_cur_y <= next_y;
                  r_state <= NEXT;
               end else begin
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               r_dx        <= w_abs_x;
               r_dy        <= -w_abs_y;
               r_sx        <= !w_diff_x[11];
               r_sy        <= !w_diff_y[11];
               r_err       <= w_abs_x - w_abs_y;
               r_pix_x     <= r_cur_x;
               r_pix_y     <= r_cur_y;
               r_pix_color <= r_col;
               r_pix_valid <= 1'b1;
               r_state     <= DRAW;
            end
            DRAW: begin
               if (pix_ready) begin
                  if (w_last_pix) begin
                     r_cur_x     <= r_tx;
                     r_cur_y     <= r_ty;
                     r_pix_valid <= 1'b0;
                     r_state     <= NEXT;
                  end else begin
                     r_err   <= w_err_next;
                     r_pix_x <= w_pix_x_next;
                     r_pix_y <= w_pix_y_next;
                  end
               end
            end
            NEXT: begin
               if (r_pc == LAST_PC) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_pc    <= r_pc + 8'd1;
                  r_state <= FETCH;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_pix_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign pc        = r_pc;
   assign pix_valid = r_pix_valid;
   assign pix_x     = r_pix_x;
   assign pix_y     = r_pix_y;
   assign pix_color = r_pix_color;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_line_sequencer.sv
// Directed bench for line_sequencer: small instruction memory, pixel capture and endpoint/shape checks.
module tb_line_sequencer;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pc;
   logic [9:0] next_x;
   logic [9:0] next_y;
   logic [2:0] ch;
   logic       pix_valid;
   logic       pix_ready = 1'b1;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic [2:0] pix_color;
   logic       busy;
   logic       done;

   logic [9:0] mem_x [0:2];
   logic [9:0] mem_y [0:2];
   logic [2:0] mem_c [0:2];

   int   n_pass = 0;
   int   n_total = 0;
   int   done_cnt;
   int   busy_cyc;
   logic [7:0] done_pc;
   pix_t q[$];
   pix_t golden[$];

   line_sequencer #(.PROG_LEN(3)) dut (
      .clk(clk), .rst(rst), .start(start), .pc(pc),
      .next_x(next_x), .next_y(next_y), .ch(ch),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   assign next_x = (pc < 8'd3) ? mem_x[pc[1:0]] : 10'd0;
   assign next_y = (pc < 8'd3) ? mem_y[pc[1:0]] : 10'd0;
   assign ch     = (pc < 8'd3) ? mem_c[pc[1:0]] : 3'd0;

   task automatic load_prog(input logic [9:0] x0, input logic [9:0] y0, input logic [2:0] c0,
                            input logic [9:0] x1, input logic [9:0] y1, input logic [2:0] c1,
                            input logic [9:0] x2, input logic [9:0] y2, input logic [2:0] c2);
      mem_x[0] = x0; mem_y[0] = y0; mem_c[0] = c0;
      mem_x[1] = x1; mem_y[1] = y1; mem_c[1] = c1;
      mem_x[2] = x2; mem_y[2] = y2; mem_c[2] = c2;
   endtask

   task automatic load_default();
      load_prog(10'd50, 10'd60, 3'b000, 10'd100, 10'd80, 3'b010, 10'd150, 10'd120, 3'b100);
   endtask

   // Pulses start, captures accepted pixels until done; extra_start >= 0 pulses start again mid-run.
   task automatic run_prog(input bit rand_ready, input int extra_start);
      bit   held;
      bit   seen_done;
      pix_t hp;
      q.delete();
      done_cnt  = 0;
      busy_cyc  = 0;
      held      = 0;
      seen_done = 0;
      done_pc   = 8'hff;
      @(posedge clk); #1;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 4000 && !seen_done; k++) begin
         @(negedge clk);
         if (held) begin
            n_total++;
            if (pix_valid === 1'b1 && {pix_x, pix_y, pix_color} === hp) n_pass++;
            else $display("FAIL stall_hold: got valid=%b (%0d,%0d,%0d) want held (%0d,%0d,%0d)",
                          pix_valid, pix_x, pix_y, pix_color, hp.x, hp.y, hp.c);
         end
         held = pix_valid && !pix_ready;
         hp   = {pix_x, pix_y, pix_color};
         if (pix_valid && pix_ready) q.push_back({pix_x, pix_y, pix_color});
         if (busy) busy_cyc++;
         if (done) begin
            done_cnt++;
            done_pc   = pc;
            seen_done = 1;
         end
         if (!seen_done) begin
            @(posedge clk); #1;
            start = (k == extra_start);
            if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
         end
      end
      start = 1'b0;
      pix_ready = 1'b1;
      n_total++;
      if (seen_done) n_pass++;
      else $display("FAIL run_timeout: done not seen, got %0d pixels", q.size());
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (pc === 8'd0 && pix_valid === 1'b0 && busy === 1'b0 && done === 1'b0) n_pass++;
      else $display("FAIL reset_ctrl: got pc=%0d valid=%b busy=%b done=%b want 0 0 0 0",
                    pc, pix_valid, busy, done);
      n_total++;
      if (pix_x === 10'd0 && pix_y === 10'd0 && pix_color === 3'd0) n_pass++;
      else $display("FAIL reset_pix: got (%0d,%0d,%0d) want (0,0,0)", pix_x, pix_y, pix_color);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_default_run();
      int x0 [0:1];
      int y0 [0:1];
      int ddx [0:1];
      int ddy [0:1];
      logic [2:0] cc [0:1];
      pix_t exp;
      x0[0] = 50;  y0[0] = 60; ddx[0] = 50; ddy[0] = 20; cc[0] = 3'b010;
      x0[1] = 100; y0[1] = 80; ddx[1] = 50; ddy[1] = 40; cc[1] = 3'b100;
      load_default();
      run_prog(1'b0, -1);
      n_total++;
      if (q.size() == 102) n_pass++;
      else $display("FAIL default_count: got %0d pixels want 102", q.size());
      n_total++;
      if (done_cnt == 1 && done_pc === 8'd2) n_pass++;
      else $display("FAIL default_done: got done_cnt=%0d pc=%0d want 1 and 2", done_cnt, done_pc);
      n_total++;
      if (busy_cyc == 111) n_pass++;
      else $display("FAIL default_latency: got %0d busy cycles want 111", busy_cyc);
      if (q.size() == 102) begin
         exp = {10'd50, 10'd60, 3'b010};
         n_total++;
         if (q[0] === exp) n_pass++;
         else $display("FAIL line1_first: got (%0d,%0d,%0d) want (50,60,2)", q[0].x, q[0].y, q[0].c);
         exp = {10'd100, 10'd80, 3'b010};
         n_total++;
         if (q[50] === exp) n_pass++;
         else $display("FAIL line1_last: got (%0d,%0d,%0d) want (100,80,2)", q[50].x, q[50].y, q[50].c);
         exp = {10'd100, 10'd80, 3'b100};
         n_total++;
         if (q[51] === exp) n_pass++;
         else $display("FAIL line2_first: got (%0d,%0d,%0d) want (100,80,4)", q[51].x, q[51].y, q[51].c);
         exp = {10'd150, 10'd120, 3'b100};
         n_total++;
         if (q[101] === exp) n_pass++;
         else $display("FAIL line2_last: got (%0d,%0d,%0d) want (150,120,4)", q[101].x, q[101].y, q[101].c);
         // x-major lines: x steps every pixel, y stays within half a pixel of the ideal line
         for (int l = 0; l < 2; l++) begin
            for (int i = 0; i <= 50; i++) begin
               int px;
               int py;
               int dev;
               px  = int'(q[51*l+i].x);
               py  = int'(q[51*l+i].y);
               dev = ddx[l] * (py - y0[l]) - ddy[l] * (px - x0[l]);
               if (dev < 0) dev = -dev;
               n_total++;
               if (px == x0[l] + i && 2 * dev <= ddx[l] && q[51*l+i].c === cc[l]) n_pass++;
               else $display("FAIL line%0d_shape[%0d]: got (%0d,%0d,%0d) want x=%0d dev2<=%0d col=%0d",
                             l + 1, i, px, py, q[51*l+i].c, x0[l] + i, ddx[l], cc[l]);
            end
         end
      end
      golden = q;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_total++;
         if (busy === 1'b0 && done === 1'b0) n_pass++;
         else $display("FAIL default_idle[%0d]: got busy=%b done=%b want 0 0", k, busy, done);
      end
   endtask

   task automatic check_golden(input string name);
      n_total++;
      if (q.size() == golden.size()) n_pass++;
      else $display("FAIL %s_count: got %0d pixels want %0d", name, q.size(), golden.size());
      for (int i = 0; i < q.size() && i < golden.size(); i++) begin
         n_total++;
         if (q[i] === golden[i]) n_pass++;
         else $display("FAIL %s_pix[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", name, i,
                       q[i].x, q[i].y, q[i].c, golden[i].x, golden[i].y, golden[i].c);
      end
   endtask

   task automatic test_stall();
      load_default();
      run_prog(1'b1, -1);
      check_golden("stall");
      n_total++;
      if (done_cnt == 1) n_pass++;
      else $display("FAIL stall_done: got %0d want 1", done_cnt);
   endtask

   task automatic test_back_to_back();
      load_default();
      run_prog(1'b0, 30);
      check_golden("b2b");
      n_total++;
      if (busy_cyc == 111 && done_cnt == 1) n_pass++;
      else $display("FAIL b2b_ignore_start: got busy_cyc=%0d done_cnt=%0d want 111 1", busy_cyc, done_cnt);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_total++;
         if (busy === 1'b0) n_pass++;
         else $display("FAIL b2b_idle[%0d]: got busy=%b want 0", k, busy);
      end
   endtask

   task automatic test_reverse();
      pix_t exp;
      load_prog(10'd100, 10'd80, 3'b000, 10'd90, 10'd85, 3'b001, 10'd90, 10'd85, 3'b011);
      run_prog(1'b0, -1);
      n_total++;
      if (q.size() == 12) n_pass++;
      else $display("FAIL reverse_count: got %0d pixels want 12", q.size());
      if (q.size() == 12) begin
         for (int i = 0; i <= 10; i++) begin
            int dev;
            dev = 10 * (int'(q[i].y) - 80) - 5 * i;
            if (dev < 0) dev = -dev;
            n_total++;
            if (int'(q[i].x) == 100 - i && 2 * dev <= 10 && q[i].c === 3'b001) n_pass++;
            else $display("FAIL reverse_pix[%0d]: got (%0d,%0d,%0d) want x=%0d col=1",
                          i, q[i].x, q[i].y, q[i].c, 100 - i);
         end
         exp = {10'd90, 10'd85, 3'b001};
         n_total++;
         if (q[10] === exp) n_pass++;
         else $display("FAIL reverse_last: got (%0d,%0d) want (90,85)", q[10].x, q[10].y);
         exp = {10'd90, 10'd85, 3'b011};
         n_total++;
         if (q[11] === exp) n_pass++;
         else $display("FAIL zero_len: got (%0d,%0d,%0d) want (90,85,3)", q[11].x, q[11].y, q[11].c);
      end
   endtask

   task automatic test_vertical();
      pix_t exp;
      load_prog(10'd100, 10'd80, 3'b000, 10'd100, 10'd70, 3'b001, 10'd100, 10'd70, 3'b011);
      run_prog(1'b0, -1);
      n_total++;
      if (q.size() == 12) n_pass++;
      else $display("FAIL vertical_count: got %0d pixels want 12", q.size());
      if (q.size() == 12) begin
         for (int i = 0; i <= 10; i++) begin
            exp = {10'd100, 10'(80 - i), 3'b001};
            n_total++;
            if (q[i] === exp) n_pass++;
            else $display("FAIL vertical_pix[%0d]: got (%0d,%0d,%0d) want (100,%0d,1)",
                          i, q[i].x, q[i].y, q[i].c, 80 - i);
         end
         exp = {10'd100, 10'd70, 3'b011};
         n_total++;
         if (q[11] === exp) n_pass++;
         else $display("FAIL vertical_zero: got (%0d,%0d,%0d) want (100,70,3)", q[11].x, q[11].y, q[11].c);
      end
   endtask

   task automatic test_reset_mid_draw();
      bit reached;
      load_default();
      q.delete();
      reached = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 500 && !reached; k++) begin
         @(negedge clk);
         if (pix_valid && pix_ready) q.push_back({pix_x, pix_y, pix_color});
         if (q.size() >= 20) reached = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      n_total++;
      if (reached && pix_valid === 1'b1) n_pass++;
      else $display("FAIL middraw_reach: got %0d pixels valid=%b want 20 and 1", q.size(), pix_valid);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (pix_valid === 1'b0 && busy === 1'b0 && pc === 8'd0 && done === 1'b0) n_pass++;
      else $display("FAIL middraw_abort: got valid=%b busy=%b pc=%0d done=%b want 0 0 0 0",
                    pix_valid, busy, pc, done);
      rst = 1'b0;
      run_prog(1'b0, -1);
      check_golden("after_reset");
   endtask

   initial begin
      load_default();
      test_reset();
      test_default_run();
      test_stall();
      test_back_to_back();
      test_reverse();
      test_vertical();
      test_reset_mid_draw();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/line_sequencer.md
Name: line_sequencer

Overview:
- Program sequencer and line rasteriser for the plotter datapath.
- Drives `pc` into the instruction memory and consumes its combinational outputs `next_x`, `next_y` and `ch`.
- For each instruction it either moves the pen without drawing, or draws a Bresenham line from the current pen position to the target. Each pixel is emitted on a valid/ready pixel stream in colour `ch`.
- Downstream of the instruction memory, upstream of the framebuffer writer.

Parameters:
- PROG_LEN, 3, number of instructions executed per run (pc 0 .. PROG_LEN-1); legal range 1..256.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle run request; honoured only in IDLE
- pc  out  8  instruction address to instruction memory
- next_x  in  10  target X from instruction memory (combinational on pc)
- next_y  in  10  target Y from instruction memory
- ch  in  3  colour; 3'b000 = pen-up move (no pixels)
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accepts pixel
- pix_x  out  10  pixel X
- pix_y  out  10  pixel Y
- pix_color  out  3  pixel colour
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE.
  - `pc`, pen position (cur_x, cur_y), `pix_x`, `pix_y` and `pix_color` = 0.
  - `pix_valid`, `busy` and `done` = 0.
  - Reset in any state, including mid-DRAW, aborts immediately. No further pixels are emitted and the pen returns to (0,0).
- Instruction memory is zero-latency: `next_x`, `next_y` and `ch` are sampled in the same cycle `pc` is presented.
- States: IDLE, FETCH, SETUP, DRAW, NEXT, DONE.
- IDLE:
  - `start` = 1 -> FETCH with `pc` = 0.
  - `start` is ignored in all other states.
- FETCH:
  - Latch tx = `next_x`, ty = `next_y`, col = `ch`.
  - If `ch` = 0: cur <= (`next_x`, `next_y`), go to NEXT; no pixel is emitted.
  - Otherwise go to SETUP.
- SETUP: using signed 12-bit arithmetic:
  - dx = |tx-cur_x|, dy = -|ty-cur_y|
  - sx = (tx >= cur_x) ? +1 : -1, sy = (ty >= cur_y) ? +1 : -1
  - err = dx+dy
  - Load `pix_x`/`pix_y` = cur, `pix_color` = col; go to DRAW.
- DRAW:
  - `pix_valid` = 1 and `pix_x`/`pix_y`/`pix_color` hold stable until `pix_valid` && `pix_ready`.
  - On a handshake, if `pix_x`==tx and `pix_y`==ty (last pixel): cur <= (tx,ty), `pix_valid` drops next cycle, go to NEXT.
  - Otherwise compute e2 = 2*err, then:
    - if e2 >= dy: err += dy, `pix_x` += sx
    - if e2 <= dx: err += dx, `pix_y` += sy
    - When both conditions hold, both updates apply in the same cycle.
  - One pixel is accepted per cycle at most. With `pix_ready` held high, throughput is 1 pixel/cycle.
- Pixel count per drawn line = max(dx, -dy) + 1. Both endpoints are included. A zero-length line emits exactly one pixel.
- NEXT:
  - `pc` == PROG_LEN-1 -> DONE.
  - Otherwise `pc` += 1 -> FETCH.
- DONE:
  - `done` = 1 for exactly one cycle, then IDLE.
  - `pc` holds PROG_LEN-1; the pen holds its final position.
  - The next `start` restarts at `pc` = 0 from the current pen position (the pen is not reset).
- Latency of a drawn instruction with `pix_ready` = 1: FETCH 1 + SETUP 1 + N pixel cycles + NEXT 1.
- Latency of a move instruction: FETCH 1 + NEXT 1.
- Coordinates never wrap, because Bresenham stays within the endpoints. Internal arithmetic is 12-bit signed so that e2 cannot overflow for 10-bit spans.

Test Plan:
- Default program (0:(50,60) ch 000; 1:(100,80) ch 010; 2:(150,120) ch 100), `pix_ready` = 1, pulse `start`:
  - Instruction 0 emits no pixels.
  - Line 1 emits 51 pixels, first (50,60), last (100,80), colour 010.
  - Line 2 emits 51 pixels, first (100,80), last (150,120), colour 100.
  - 102 pixels total; `done` pulses once; `busy` falls the cycle after `done`.
- Same program with `pix_ready` toggling in a random pattern -> identical 102-pixel sequence; outputs stable while stalled; no pixel duplicated or dropped.
- Bench memory with pen at (100,80) and target (90,85) ch 001 -> 11 pixels, X decreasing 100..90, final (90,85). Vertical target (100,70) -> 11 pixels with X constant.
- Target equal to current position, ch 011 -> exactly one pixel at that position, colour 011, then NEXT.
- Assert `rst` while DRAW is on pixel 20 of line 1 -> next cycle `pix_valid` = 0, `busy` = 0, `pc` = 0; a subsequent `start` reproduces the full 102-pixel run.
- `start` pulsed during DRAW is ignored. A second `start` after `done` begins at `pc` = 0 with pen at (150,120), so instruction 0 moves to (50,60) and the line output matches the first run.
